// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle core sequencer.
// State codes are visible on the debug port, so they are fixed values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  localparam logic [1:0] OP_ILL     = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: state -> datapath control word.
// mem_ready only qualifies the fetch strobes so IR/PC load once per fetch.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.next_pc    = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        // held through the whole wait; memory commits on its ready cycle
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main sequencer for the multicycle core: state register, next-state,
// sticky illegal-opcode flag and reset gating of the write strobes.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when memory ready
// DECODE   | read registers, dispatch on Op
// MEMADR   | compute load/store address
// MEMREAD  | wait for load data
// MEMWB    | write load data to register file
// MEMWRITE | drive store until memory ready
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | compute branch target
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state_q, state_d;
  logic   illegal_q;
  ctrl_t  ctrl;

  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && Op == OP_ILL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  // strobes must be dead during reset even though FETCH shows MemReady
  assign IRWrite   = ctrl.ir_write & reset;
  assign NextPC    = ctrl.next_pc  & reset;
  assign RegW      = ctrl.reg_w    & reset;
  assign MemW      = ctrl.mem_w    & reset;
  assign Branch    = ctrl.branch   & reset;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ResultSrc = ctrl.result_src;
  assign Illegal   = illegal_q;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into its expected
// per-cycle state list (with memory waits), driven and checked cycle by cycle.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_illegal = 1'b0;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                 MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BRANCH = 9;

  typedef struct {
    int st;
    bit mr;
    bit hold;
  } step_t;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,RegW,MemW,Branch}
  function automatic logic [13:0] exp_ctrl(input int st, input bit mr, input bit in_rst);
    logic irw = 0, adr = 0, aop = 0, rw = 0, mw = 0, br = 0;
    logic [1:0] sa = 0, sb = 0, res = 0;
    case (st)
      FETCH:    begin sa = 1; sb = 2; res = 2; irw = mr; end
      DECODE:   begin sa = 1; sb = 2; res = 2; end
      MEMADR:   begin sa = 0; sb = 1; end
      MEMREAD:  begin adr = 1; res = 0; end
      MEMWB:    begin res = 1; rw = 1; end
      MEMWRITE: begin adr = 1; res = 0; mw = 1; end
      EXECUTER: begin sa = 0; sb = 0; aop = 1; end
      EXECUTEI: begin sa = 0; sb = 1; aop = 1; end
      ALUWB:    begin res = 0; rw = 1; end
      BRANCH:   begin sa = 0; sb = 1; res = 2; br = 1; end
      default:  ;
    endcase
    if (in_rst) begin irw = 0; rw = 0; mw = 0; br = 0; end
    return {irw, irw, adr, sa, sb, aop, res, rw, mw, br};
  endfunction

  task automatic check_cycle(input int st, input bit in_rst);
    check_eq("state", State, st);
    check_eq("ctrl", {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, RegW, MemW, Branch},
             exp_ctrl(st, MemReady, in_rst));
    check_eq("illegal", Illegal, exp_illegal);
  endtask

  // Entered and left at posedge+1. abort_at: index of the step during which reset is pulled.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int wf, input int wm, input int abort_at);
    step_t q[$];
    for (int k = 0; k < wf; k++) q.push_back('{FETCH, 1'b0, 1'b0});
    q.push_back('{FETCH, 1'b1, 1'b0});
    q.push_back('{DECODE, 1'($urandom), 1'b1});
    case (op)
      2'b00: begin
        q.push_back('{funct[5] ? EXECUTEI : EXECUTER, 1'($urandom), 1'b0});
        q.push_back('{ALUWB, 1'($urandom), 1'b0});
      end
      2'b01: begin
        q.push_back('{MEMADR, 1'($urandom), 1'b1});
        if (funct[0]) begin
          for (int k = 0; k < wm; k++) q.push_back('{MEMREAD, 1'b0, 1'b0});
          q.push_back('{MEMREAD, 1'b1, 1'b0});
          q.push_back('{MEMWB, 1'($urandom), 1'b0});
        end else begin
          for (int k = 0; k < wm; k++) q.push_back('{MEMWRITE, 1'b0, 1'b0});
          q.push_back('{MEMWRITE, 1'b1, 1'b0});
        end
      end
      2'b10: q.push_back('{BRANCH, 1'($urandom), 1'b0});
      default: ;
    endcase

    for (int i = 0; i < q.size(); i++) begin
      MemReady = q[i].mr;
      if (q[i].hold) begin
        Op = op; Funct = funct;
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom);
      end
      #1;
      check_cycle(q[i].st, 1'b0);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        exp_illegal = 1'b0;
        check_cycle(FETCH, 1'b1);
        @(posedge clk); #1;
        check_cycle(FETCH, 1'b1);
        reset = 1'b1;
        return;
      end
      if (q[i].st == DECODE && op == 2'b11) exp_illegal = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; MemReady = 1'b1; Op = 2'b00; Funct = 6'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_cycle(FETCH, 1'b1);
    end
    reset = 1'b1;

    run_instr(2'b00, 6'b000000, 0, 0, -1);   // data-proc register: 0,1,6,8
    run_instr(2'b00, 6'b100000, 1, 0, -1);   // data-proc immediate
    run_instr(2'b01, 6'b000001, 0, 2, -1);   // load, 2 wait cycles in MEMREAD
    run_instr(2'b01, 6'b000000, 0, 1, -1);   // store, 1 wait cycle
    run_instr(2'b10, 6'b000000, 0, 0, -1);   // branch
    run_instr(2'b11, 6'b000000, 0, 0, -1);   // illegal -> sticky flag
    run_instr(2'b00, 6'b000000, 2, 0, -1);
    run_instr(2'b01, 6'b000000, 0, 3, 4);    // reset during MEMWRITE while MemW=1
    run_instr(2'b00, 6'b000000, 0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      int ab = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Main sequencing state machine for the multicycle ARM core. It walks each instruction through fetch, decode, execute, memory and writeback, one state per cycle. It drives the datapath mux selects and the raw write strobes (RegW, MemW, Branch, NextPC, IRWrite). The write strobes pass through the existing conditional-logic block, which gates them with the condition check. Variable-latency memory is supported through a single ready input.

## Interface
Parameters: none.
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- Op  in  2  instruction bits [27:26]: 00 data-proc, 01 memory, 10 branch, 11 illegal
- Funct  in  6  instruction bits [25:20]; Funct[5] = I (immediate), Funct[0] = S/L (load when Op=01)
- MemReady  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  raw PC-write strobe (fetch)
- AdrSrc  out  1  0 = PC, 1 = ALU result as memory address
- ALUSrcA  out  2  00 = register A, 01 = PC
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ALUOp  out  1  1 = decode ALU function from Funct, 0 = ADD
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- RegW  out  1  raw register write
- MemW  out  1  raw memory write
- Branch  out  1  raw branch strobe
- Illegal  out  1  sticky; set on decode of Op=11
- State  out  4  current state encoding, for debug

## Operation
States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. All other encodings go to FETCH on the next edge.

Transitions:
- FETCH → DECODE if MemReady, else stay in FETCH.
- DECODE: Op=01 → MEMADR; Op=00 & Funct[5]=0 → EXECUTER; Op=00 & Funct[5]=1 → EXECUTEI; Op=10 → BRANCH; Op=11 → FETCH and set Illegal.
- MEMADR → MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD → MEMWB if MemReady, else stay in MEMREAD.
- MEMWRITE → FETCH if MemReady, else stay in MEMWRITE.
- EXECUTER and EXECUTEI → ALUWB.
- MEMWB, ALUWB and BRANCH → FETCH.

Outputs are Moore. Any field not listed is 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite = NextPC = MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 on every cycle of the state.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.

Illegal is cleared only by reset.

## Timing
- Reset asserted: State=FETCH immediately, asynchronously. Illegal=0.
- While reset is low, IRWrite, NextPC, RegW, MemW and Branch are forced to 0. Mux selects show the FETCH values.
- First fetch: on the first rising edge after reset deasserts, the block is in FETCH and MemReady is sampled.
- Instruction latency, with MemReady held at 1:
  - data-proc: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
- Each extra cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Strobes go high only in the cycle before the state leaves:
  - IRWrite and NextPC are high exactly one cycle per fetch.
  - RegW and Branch are each high exactly one cycle.
  - MemW stays high for the whole MEMWRITE wait. The memory commits the write on the MemReady cycle.
- Op and Funct are sampled only in DECODE and MEMADR. IR is stable there, so no registering is needed.
- Reset mid-instruction: the instruction is abandoned with no write strobe on the following edges, and execution restarts in FETCH.

## Structure
- Package mc_ctrl_pkg holds:
  - typedef enum logic [3:0] state_t, with the encodings above
  - localparams for the ALUSrcA, ALUSrcB and ResultSrc codes
  - localparams for the Op codes
- Sub-module mc_ctrl_outdec: combinational state_t → output-control-word decoder. It takes MemReady only for the FETCH strobes.
- Top level holds the state register, next-state logic, the Illegal flop and reset gating.

## Test plan
- Reset low for 3 cycles, then high, MemReady=1: State=0 and all strobes 0 during reset. In the first active cycle, IRWrite=NextPC=1.
- Data-proc register (Op=00, Funct=000000), MemReady=1: State sequence 0,1,6,8,0. RegW=1 only in state 8 with ResultSrc=00.
- Load (Op=01, Funct[0]=1), MemReady low for 2 cycles in MEMREAD: sequence 0,1,2,3,3,3,4,0. RegW=1 once, with ResultSrc=01.
- Store (Op=01, Funct[0]=0), MemReady low for 1 cycle: sequence 0,1,2,5,5,0. MemW=1 for both cycles in state 5, AdrSrc=1.
- Branch (Op=10): sequence 0,1,9,0, with Branch=1 and ALUSrcB=01 in state 9. Then Op=11: DECODE → FETCH, Illegal=1 and held until reset.
- Reset dropped while in MEMWRITE with MemW=1: MemW=0 within the same cycle and State=0. No RegW, Branch or MemW pulses until a new fetch completes.
